// File: rtl/instr_sequencer.sv
// Byte-stream instruction sequencer driving register-bank write controls.
// Optional SEQ_OVERLAP_FETCH_EN overlaps the next fetch with EXEC.
module instr_sequencer (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] INSTR,
  input  logic       IVALID,
  output logic       IREADY,
  output logic [7:0] PC,
  output logic       MS1,
  output logic       MS0,
  output logic       RS2,
  output logic       RS1,
  output logic       RS0,
  output logic       E,
  output logic [7:0] IMM,
  output logic [2:0] SRC,
  output logic [2:0] ALUOP,
  output logic       HALTED
);

`ifdef SEQ_OVERLAP_FETCH_EN
  localparam logic OVL = 1'b1;
`else
  localparam logic OVL = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_IMM,
    S_EXEC,
    S_HALT
  } state_t;

  state_t     r_state;
  logic       r_ready;
  logic       r_e;
  logic       r_halted;
  logic [7:0] r_pc;
  logic [7:0] r_imm;
  logic [1:0] r_ms;
  logic [2:0] r_rs;
  logic [2:0] r_src;
  logic [2:0] r_alu;

  logic w_hs;
  logic w_mov;
  logic w_alu;
  logic w_ldi;
  logic w_halt;
  logic w_clr;

  assign w_hs   = IVALID & r_ready;
  assign w_mov  = INSTR[7:6] == 2'b00;
  assign w_alu  = INSTR[7:6] == 2'b01;
  assign w_ldi  = INSTR[7:6] == 2'b10;
  assign w_halt = (INSTR[7:6] == 2'b11) & (INSTR[2:0] == 3'b111);
  assign w_clr  = (INSTR[7:6] == 2'b11) & (INSTR[2:0] != 3'b111);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_e      <= 1'b0;
      r_halted <= 1'b0;
      r_pc     <= 8'h00;
      r_imm    <= 8'h00;
      r_ms     <= 2'b11;
      r_rs     <= 3'b000;
      r_src    <= 3'b000;
      r_alu    <= 3'b000;
    end else begin
      if (w_hs)
        r_pc <= r_pc + 8'd1;
      unique case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_ready <= 1'b1;
          r_e     <= 1'b0;
        end
        S_FETCH, S_EXEC: begin
          // EXEC only accepts an opcode when overlap is built in
          if (w_hs) begin
            unique case (1'b1)
              w_halt: begin
                r_state  <= S_HALT;
                r_ready  <= 1'b0;
                r_e      <= 1'b0;
                r_halted <= 1'b1;
              end
              w_ldi: begin
                r_ms    <= 2'b10;
                r_rs    <= INSTR[5:3];
                r_state <= S_IMM;
                r_ready <= 1'b1;
                r_e     <= 1'b0;
              end
              w_mov, w_alu, w_clr: begin
                r_ms    <= {w_clr, w_mov | w_clr};
                r_rs    <= INSTR[5:3];
                if (w_mov)
                  r_src <= INSTR[2:0];
                if (w_alu)
                  r_alu <= INSTR[2:0];
                r_state <= S_EXEC;
                r_ready <= OVL;
                r_e     <= 1'b1;
              end
              default: r_state <= r_state;
            endcase
          end else if (r_state == S_EXEC) begin
            r_state <= S_FETCH;
            r_ready <= 1'b1;
            r_e     <= 1'b0;
          end
        end
        S_IMM: begin
          if (w_hs) begin
            r_imm   <= INSTR;
            r_state <= S_EXEC;
            r_ready <= OVL;
            r_e     <= 1'b1;
          end
        end
        S_HALT: begin
          r_ready <= 1'b0;
          r_e     <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_e     <= 1'b0;
        end
      endcase
    end
  end

  assign IREADY          = r_ready;
  assign E               = r_e;
  assign HALTED          = r_halted;
  assign PC              = r_pc;
  assign IMM             = r_imm;
  assign {MS1, MS0}      = r_ms;
  assign {RS2, RS1, RS0} = r_rs;
  assign SRC             = r_src;
  assign ALUOP           = r_alu;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: rule-based model, per-cycle compare,
// directed vectors and a negative-edge register-bank write recorder.
module tb_instr_sequencer;

`ifdef SEQ_OVERLAP_FETCH_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] INSTR;
  logic       IVALID;
  logic       IREADY;
  logic [7:0] PC;
  logic       MS1, MS0, RS2, RS1, RS0, E;
  logic [7:0] IMM;
  logic [2:0] SRC, ALUOP;
  logic       HALTED;

  int checks = 0;
  int errors = 0;
  int writes = 0;

  instr_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .INSTR(INSTR), .IVALID(IVALID),
    .IREADY(IREADY), .PC(PC), .MS1(MS1), .MS0(MS0),
    .RS2(RS2), .RS1(RS1), .RS0(RS0), .E(E), .IMM(IMM),
    .SRC(SRC), .ALUOP(ALUOP), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  // model: what has been accepted so far, not how the FSM encodes it
  bit       m_live, m_halted, m_want_imm, m_e;
  int       m_pc, m_ms, m_rs, m_src, m_alu, m_imm;
  int       m_hs_cnt = 0;

  function automatic bit m_ready();
    return m_live && !m_halted && (!m_e || OVL);
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_live = 0; m_halted = 0; m_want_imm = 0; m_e = 0;
      m_pc = 0; m_ms = 3; m_rs = 0; m_src = 0; m_alu = 0; m_imm = 0;
    end else begin
      bit hs, wr;
      int op, cls;
      hs = IVALID && m_ready();
      wr = 0;
      if (hs) begin
        m_hs_cnt++;
        m_pc = (m_pc + 1) % 256;
        op = INSTR;
        cls = op / 64;
        if (m_want_imm) begin
          m_imm = op;
          m_want_imm = 0;
          wr = 1;
        end else if (cls == 3 && op % 8 == 7) begin
          m_halted = 1;
        end else begin
          m_rs = (op / 8) % 8;
          if (cls == 2) begin
            m_ms = 2;
            m_want_imm = 1;
          end else begin
            wr = 1;
            if (cls == 0) begin m_ms = 1; m_src = op % 8; end
            if (cls == 1) begin m_ms = 0; m_alu = op % 8; end
            if (cls == 3) m_ms = 3;
          end
        end
      end
      m_e = wr;
      m_live = 1;
    end
  end

  // register bank captures on the falling edge
  always @(negedge CLK) if (E === 1'b1) writes++;

  always @(negedge CLK) begin
    logic [39:0] act, exp;
    act = {IREADY, E, HALTED, MS1, MS0, RS2, RS1, RS0,
           PC, IMM, 2'b00, SRC, ALUOP, 8'h00};
    exp = {m_ready(), m_e, m_halted, m_ms[1:0], m_rs[2:0],
           m_pc[7:0], m_imm[7:0], 2'b00, m_src[2:0], m_alu[2:0], 8'h00};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle t=%0t got %h expected %h", $time, act, exp);
    end
  end

  task automatic lit(input string n, input logic [7:0] a,
                     input logic [7:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, x);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_hs(input string n);
    int target;
    target = m_hs_cnt + 1;
    for (int i = 0; i < 50 && m_hs_cnt < target; i++) step();
    if (m_hs_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s handshake timeout got 0 expected 1", n);
    end
  endtask

  initial begin
    logic [3:0] epat;
    int base, w0, bad;
    RST_N = 1'b0; IVALID = 1'b0; INSTR = 8'h00;
    step(); step();
    lit("rst_pc", PC, 8'h00);
    lit("rst_ms", {6'd0, MS1, MS0}, 8'h03);
    lit("rst_rdy", {7'd0, IREADY}, 8'h00);

    // MOV R1,R3
    RST_N = 1'b1; INSTR = 8'h0B; IVALID = 1'b1;
    step();
    lit("idle_e", {7'd0, E}, 8'h00);
    step();
    lit("mov_e", {7'd0, E}, 8'h01);
    lit("mov_ms", {6'd0, MS1, MS0}, 8'h01);
    lit("mov_rs", {5'd0, RS2, RS1, RS0}, 8'h01);
    lit("mov_src", {5'd0, SRC}, 8'h03);
    lit("mov_pc", PC, 8'h01);
    lit("mov_wr", writes[7:0], 8'h01);
    IVALID = 1'b0;
    step();

    // LDI R2,0xA5 with a stall before the immediate
    INSTR = 8'h97; IVALID = 1'b1;
    wait_hs("ldi_op");
    lit("ldi_e0", {7'd0, E}, 8'h00);
    IVALID = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (E !== 1'b0) bad++;
    end
    lit("ldi_stall", bad[7:0], 8'h00);
    INSTR = 8'hA5; IVALID = 1'b1;
    wait_hs("ldi_imm");
    lit("ldi_e", {7'd0, E}, 8'h01);
    lit("ldi_ms", {6'd0, MS1, MS0}, 8'h02);
    lit("ldi_rs", {5'd0, RS2, RS1, RS0}, 8'h02);
    lit("ldi_imm", IMM, 8'hA5);
    lit("ldi_pc", PC, 8'h03);
    IVALID = 1'b0;
    step();

    // two ALU R1 op6 back-to-back
    INSTR = 8'h4E; IVALID = 1'b1;
    base = m_hs_cnt;
    for (int i = 0; i < 4; i++) begin
      step();
      epat[3-i] = E;
      if (m_hs_cnt == base + 2) IVALID = 1'b0;
    end
    lit("alu_epat", {4'd0, epat}, OVL ? 8'h0C : 8'h0A);
    lit("alu_rs", {5'd0, RS2, RS1, RS0}, 8'h01);
    lit("alu_op", {5'd0, ALUOP}, 8'h06);
    step();

    // CLR stream until PC wraps
    INSTR = 8'hC0; IVALID = 1'b1;
    for (int i = 0; i < 1200 && m_pc != 255; i++) step();
    lit("pc_ff", PC, 8'hFF);
    wait_hs("pc_wrap");
    lit("pc_wrap", PC, 8'h00);
    IVALID = 1'b0;
    step(); step();

    // reset while CLK is high during EXEC
    INSTR = 8'h08; IVALID = 1'b1;
    @(posedge CLK);
    #2;
    lit("exec_e", {7'd0, E}, 8'h01);
    w0 = writes;
    RST_N = 1'b0;
    #1;
    lit("rst_e_now", {7'd0, E}, 8'h00);
    IVALID = 1'b0;
    step();
    lit("rst_nowr", writes[7:0], w0[7:0]);
    lit("rst2_pc", PC, 8'h00);
    lit("rst2_ms", {6'd0, MS1, MS0}, 8'h03);
    lit("rst2_rs", {5'd0, RS2, RS1, RS0}, 8'h00);
    lit("rst2_imm", IMM, 8'h00);
    lit("rst2_misc", {SRC, ALUOP, IREADY, HALTED}, 8'h00);

    // HALT ignores further input
    RST_N = 1'b1;
    step();
    INSTR = 8'hFF; IVALID = 1'b1;
    wait_hs("halt");
    lit("halted", {7'd0, HALTED}, 8'h01);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (IREADY !== 1'b0 || E !== 1'b0) bad++;
    end
    lit("halt_hold", bad[7:0], 8'h00);
    lit("halt_pc", PC, 8'h01);
    RST_N = 1'b0;
    #1;
    lit("unhalt", {6'd0, HALTED, IREADY}, 8'h00);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Fetches instruction bytes from program memory over a valid/ready handshake and decodes them.
- Drives the register bank's write controls (write-source select, destination select, global write enable), the immediate byte, and the ALU/read-port selects.
- Sits directly upstream of the register bank.
- Updates on the rising edge of CLK, so every control it drives is stable half a cycle before the register bank captures on the falling edge.

## Interface
Parameters:
- none

Ports (one clock; reset is asynchronous and active-low):
- CLK  input  1  system clock; all state updates on the rising edge
- RST_N  input  1  asynchronous active-low reset
- INSTR  input  8  instruction byte from program memory
- IVALID  input  1  INSTR holds a valid byte
- IREADY  output  1  sequencer accepts INSTR this cycle
- PC  output  8  address of the next byte to fetch
- MS1, MS0  output  1 each  write-source select: 00 ALU, 01 REG, 10 IMM, 11 zero
- RS2, RS1, RS0  output  1 each  destination register index
- E  output  1  global write enable to the register bank
- IMM  output  8  immediate byte
- SRC  output  3  source register index for the read port (MOV)
- ALUOP  output  3  ALU function code
- HALTED  output  1  sequencer stopped

## Operation
- Opcode byte format: [7:6] class, [5:3] ddd = destination, [2:0] field.
  - 00 ddd sss — MOV: MS=01, RS=ddd, SRC=sss; 1 byte.
  - 01 ddd fff — ALU: MS=00, RS=ddd, ALUOP=fff; 1 byte.
  - 10 ddd xxx — LDI: MS=10, RS=ddd; the second byte goes to IMM; 2 bytes.
  - 11 ddd 111 — HALT, regardless of ddd.
  - 11 ddd other — CLR: MS=11, RS=ddd; 1 byte.
- A handshake occurs on a rising edge with IVALID=1 and IREADY=1.
- Each handshake increments PC by 1, wrapping 8'hFF to 8'h00.
- States and transitions:
  - IDLE: IREADY=0, E=0. Goes unconditionally to FETCH on the next edge.
  - FETCH: IREADY=1, E=0. On handshake, latch the opcode's controls. Next state is IMM for LDI, HALT for HALT, otherwise EXEC. With no handshake, stay in FETCH.
  - IMM: IREADY=1, E=0. On handshake, latch IMM=INSTR and go to EXEC; otherwise stay in IMM.
  - EXEC: E=1 for exactly one cycle, IREADY=0. Go to FETCH.
  - HALT: IREADY=0, E=0, HALTED=1. Remain here until reset.
- MS, RS, SRC, ALUOP and IMM are registered.
  - They change only on handshake edges.
  - They hold their value through EXEC and afterwards.
- Reset values: state IDLE, PC=0, MS1=MS0=1, RS=000, E=0, IMM=0, SRC=0, ALUOP=0, IREADY=0, HALTED=0.
- Reset mid-operation:
  - RST_N low forces IDLE asynchronously and clears E immediately.
  - If RST_N falls during a high phase of EXEC, the pending register-bank write is dropped.
  - A partially fetched LDI is discarded.
- IVALID dropping during IMM: the sequencer waits in IMM indefinitely, with E=0.

## Timing
- 1-byte instruction accepted at rising edge n:
  - E=1 from edge n to edge n+1.
  - The register bank writes on the falling edge within that cycle.
- LDI: opcode accepted at edge n, immediate at edge m (m>n); E=1 in cycle m..m+1.
- Throughput without overlap is 2 cycles per 1-byte instruction and 3 per LDI with IVALID held high.
- The first IREADY=1 is one cycle after RST_N deasserts, because IDLE lasts one cycle.

## Configuration
- Macro: SEQ_OVERLAP_FETCH_EN.
- Defined:
  - EXEC asserts IREADY=1.
  - A handshake in EXEC is decoded exactly as in FETCH and selects the next state directly.
  - The new controls load on the same edge that ends E.
  - Back-to-back 1-byte instructions therefore sustain E=1 every cycle.
  - Throughput is 1 cycle per 1-byte instruction and 2 per LDI.
- Undefined: EXEC asserts IREADY=0, and the behaviour is as described above.

## Test plan
- Reset, then stream 8'h0B (MOV R1,R3) with IVALID=1:
  - IREADY=0 in the first cycle after reset.
  - Handshake in the next cycle; then E=1 for one cycle with MS=01, RS=001, SRC=011.
  - PC=1.
- Stream 8'h97, 8'hA5 (LDI R2,0xA5):
  - E stays 0 until the second handshake.
  - Then E=1 with MS=10, RS=010, IMM=8'hA5; PC advances by 2.
- Stream 8'h4E, 8'h4E (ALU R1, op 6) with IVALID held high:
  - Without the macro: E pulses at cycles 2 and 4.
  - With SEQ_OVERLAP_FETCH_EN: E is high for 2 consecutive cycles with RS=001, ALUOP=110.
- Stream 8'hFF:
  - HALTED=1; IREADY and E stay 0 for 20 cycles despite IVALID=1.
  - RST_N low returns to IDLE with HALTED=0.
- Preload PC to 8'hFF by streaming 255 CLR bytes (8'hC0), then one more byte: PC wraps to 8'h00.
- Assert RST_N low while CLK is high during EXEC:
  - E falls immediately, and the register-bank model records no write.
  - All outputs return to their reset values.
